// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, fault causes,
// FSM state encoding and size/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Byte-lane mask for an access of 2**size bytes, before lane shifting.
  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Stores never sign-extend, so only the signed codes (and D on RV64) are legal for them.
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store,
                                        input logic rv64);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_D:             return rv64;
      F3_BU, F3_HU:     return !is_store;
      F3_WU:            return rv64 && !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the XLEN core side and the BUS_WIDTH bus side:
// store data/byte-enable placement and load extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUS_WIDTH = 32,
  localparam int NB       = BUS_WIDTH / 8,
  localparam int OFF_W    = $clog2(NB)
) (
  input  logic [OFF_W-1:0]     st_off,
  input  logic [1:0]           st_size,
  input  logic [XLEN-1:0]      st_data,
  output logic [NB-1:0]        st_byte_en,
  output logic [BUS_WIDTH-1:0] st_bus_data,
  input  logic [OFF_W-1:0]     ld_off,
  input  logic [1:0]           ld_size,
  input  logic                 ld_unsigned,
  input  logic [BUS_WIDTH-1:0] ld_bus_data,
  output logic [XLEN-1:0]      ld_data
);

  // Bits of an XLEN word covered by an access of 2**size bytes.
  function automatic logic [XLEN-1:0] size_keep(input logic [1:0] size);
    int nbits;
    nbits = 8 << size;
    if (nbits >= XLEN) return '1;
    return (XLEN'(1) << nbits) - XLEN'(1);
  endfunction

  logic [XLEN-1:0] st_keep;
  logic [XLEN-1:0] ld_keep;
  logic [XLEN-1:0] ld_top;
  logic [XLEN-1:0] ld_val;
  logic            ld_neg;

  // Store side: trim data to the access size so unused lanes read as zero, then shift into place.
  always_comb begin
    st_keep     = size_keep(st_size);
    st_byte_en  = NB'(byte_mask(st_size)) << st_off;
    st_bus_data = BUS_WIDTH'(st_data & st_keep) << {st_off, 3'b000};
  end

  // Load side: bring the addressed lanes down to bit 0, trim, and extend from the access MSB.
  always_comb begin
    ld_val  = XLEN'(ld_bus_data >> {ld_off, 3'b000});
    ld_keep = size_keep(ld_size);
    ld_top  = ld_keep & ~(ld_keep >> 1);
    ld_neg  = !ld_unsigned && |(ld_val & ld_top);
    ld_data = (ld_val & ld_keep) | (ld_neg ? ~ld_keep : '0);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per core memory instruction, stalling
// the core while it is in flight and reporting faults on completion.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for req_read/req_write; faults resolve straight to DONE
//   REQ     | bus_valid held with stable payload until bus_ready or timeout
//   RESP    | read accepted, waiting for bus_resp_valid or timeout
//   DONE    | done pulse, stall released; always returns to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_read,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [XLEN-1:0]        req_addr,
  input  logic [XLEN-1:0]        req_write_data,
  output logic                   stall,
  output logic                   done,
  output logic [XLEN-1:0]        load_data,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic                   bus_write,
  output logic [XLEN-1:0]        bus_addr,
  output logic [BUS_WIDTH/8-1:0] bus_byte_en,
  output logic [BUS_WIDTH-1:0]   bus_write_data,
  input  logic                   bus_resp_valid,
  input  logic [BUS_WIDTH-1:0]   bus_read_data
);

  localparam int NB    = BUS_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter holds the REQ/RESP cycles left after the current one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic RV64 = (XLEN == 64);

  lsu_state_e          state_q, state_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_write_q, bus_write_d;
  logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
  logic [NB-1:0]       bus_byte_en_q, bus_byte_en_d;
  logic [BUS_WIDTH-1:0] bus_write_data_q, bus_write_data_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_cause_q, fault_cause_d;
  logic [XLEN-1:0]     load_data_q, load_data_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                 req_any;
  logic                 req_illegal;
  logic                 req_misaligned;
  logic                 timeout_hit;
  logic [NB-1:0]        st_byte_en;
  logic [BUS_WIDTH-1:0] st_bus_data;
  logic [XLEN-1:0]      ld_data;

  assign req_any        = req_read | req_write;
  assign req_illegal    = (req_read & req_write) | !funct3_legal(req_funct3, req_write, RV64);
  assign req_misaligned = misaligned(req_funct3[1:0], req_addr[2:0]);
  assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (cnt_q == '0);

  lsu_lane_align #(
    .XLEN      (XLEN),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_lane_align (
    .st_off      (req_addr[OFF_W-1:0]),
    .st_size     (req_funct3[1:0]),
    .st_data     (req_write_data),
    .st_byte_en  (st_byte_en),
    .st_bus_data (st_bus_data),
    .ld_off      (off_q),
    .ld_size     (funct3_q[1:0]),
    .ld_unsigned (funct3_q[2]),
    .ld_bus_data (bus_read_data),
    .ld_data     (ld_data)
  );

  // Next-state and registered-output logic; handshake/response wins over a same-cycle timeout.
  always_comb begin
    state_d          = state_q;
    bus_write_d      = bus_write_q;
    bus_addr_d       = bus_addr_q;
    bus_byte_en_d    = bus_byte_en_q;
    bus_write_data_d = bus_write_data_q;
    fault_d          = 1'b0;
    fault_cause_d    = fault_cause_q;
    load_data_d      = load_data_q;
    funct3_d         = funct3_q;
    off_d            = off_q;
    cnt_d            = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          load_data_d = '0;
          if (req_illegal) begin
            state_d       = ST_DONE;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_ILLEGAL;
          end else if (req_misaligned) begin
            state_d       = ST_DONE;
            fault_d       = 1'b1;
            fault_cause_d = CAUSE_MISALIGN;
          end else begin
            state_d          = ST_REQ;
            fault_cause_d    = CAUSE_NONE;
            bus_write_d      = req_write;
            bus_addr_d       = req_addr & ~XLEN'(NB - 1);
            bus_byte_en_d    = st_byte_en;
            bus_write_data_d = req_write ? st_bus_data : '0;
            funct3_d         = req_funct3;
            off_d            = req_addr[OFF_W-1:0];
            cnt_d            = CNT_LOAD;
          end
        end
      end
      ST_REQ: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (bus_ready) begin
          state_d = bus_write_q ? ST_DONE : ST_RESP;
        end else if (timeout_hit) begin
          state_d       = ST_DONE;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (bus_resp_valid) begin
          state_d     = ST_DONE;
          load_data_d = ld_data;
        end else if (timeout_hit) begin
          state_d       = ST_DONE;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    bus_valid_d = (state_d == ST_REQ);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      bus_valid_q      <= 1'b0;
      bus_write_q      <= 1'b0;
      bus_addr_q       <= '0;
      bus_byte_en_q    <= '0;
      bus_write_data_q <= '0;
      done_q           <= 1'b0;
      fault_q          <= 1'b0;
      fault_cause_q    <= CAUSE_NONE;
      load_data_q      <= '0;
      funct3_q         <= '0;
      off_q            <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      bus_valid_q      <= bus_valid_d;
      bus_write_q      <= bus_write_d;
      bus_addr_q       <= bus_addr_d;
      bus_byte_en_q    <= bus_byte_en_d;
      bus_write_data_q <= bus_write_data_d;
      done_q           <= done_d;
      fault_q          <= fault_d;
      fault_cause_q    <= fault_cause_d;
      load_data_q      <= load_data_d;
      funct3_q         <= funct3_d;
      off_q            <= off_d;
      cnt_q            <= cnt_d;
    end
  end

  // Stall is combinational only in IDLE so the request is held from its first cycle.
  assign stall = !reset && ((state_q == ST_IDLE && req_any) ||
                            state_q == ST_REQ || state_q == ST_RESP);

  assign done           = done_q;
  assign fault          = fault_q;
  assign fault_cause    = fault_cause_q;
  assign load_data      = load_data_q;
  assign bus_valid      = bus_valid_q;
  assign bus_write      = bus_write_q;
  assign bus_addr       = bus_addr_q;
  assign bus_byte_en    = bus_byte_en_q;
  assign bus_write_data = bus_write_data_q;

endmodule
